// File: rtl/opamp_trim_cal_ctrl.sv
// ---------------------------------------------------------------------------
// opamp_trim_cal_ctrl
//   Successive-approximation offset-trim calibration controller for an opamp
//   whose output is used as a comparator while calibrating. A run zeroes the
//   trim DAC, waits for the analog path to settle, then resolves the code from
//   MSB to LSB. Each bit gets one settle window followed by a one-cycle
//   comparator decision. A manual trim code can be loaded while idle. An abort
//   restores the code and valid flag that were in place before the run.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   start_i      begin a calibration run (IDLE only)
//   abort_i      cancel a run in progress (any non-IDLE state)
//   load_i       manual trim load strobe (IDLE only, wins over start_i)
//   load_code_i  manual trim value
//   cmp_in_i     asynchronous comparator output, 1 = trial code too high
//   trim_o       code driven to the offset-trim DAC
//   cal_en_o     input-short switch closed / feedback loop opened
//   busy_o       high in every state other than IDLE
//   done_o       one-cycle pulse when a run completes
//   valid_o      trim_o holds a calibrated or loaded code
// ---------------------------------------------------------------------------
module opamp_trim_cal_ctrl #(
  parameter int TRIM_W        = 6,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              load_i,
  input  logic [TRIM_W-1:0] load_code_i,
  input  logic              cmp_in_i,
  output logic [TRIM_W-1:0] trim_o,
  output logic              cal_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              valid_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [CNT_W-1:0]  SETTLE   = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(TRIM_W - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [TRIM_W-1:0] TRIM_LSB = TRIM_W'(1);
  localparam logic [TRIM_W-1:0] TRIM_MSB = TRIM_LSB << (TRIM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_DECIDE,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [TRIM_W-1:0] trim_q;
  logic [TRIM_W-1:0] bk_trim_q;
  logic              bk_valid_q;
  logic              cal_en_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              cmp_s1_q;
  logic              cmp_s2_q;

  // Two-flop synchronizer; only cmp_s2_q is ever sampled by the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_s1_q <= 1'b0;
      cmp_s2_q <= 1'b0;
    end else begin
      cmp_s1_q <= cmp_in_i;
      cmp_s2_q <= cmp_s1_q;
    end
  end

  // Code resolved by a DECIDE cycle: drop the trial bit if the comparator
  // says the code is too high, then raise the next lower trial bit (if any)
  // so it is already in place for the following settle window.
  logic [TRIM_W-1:0] cur_bit;
  logic [TRIM_W-1:0] trim_d;

  always_comb begin
    cur_bit = TRIM_LSB << idx_q;
    trim_d  = cmp_s2_q ? (trim_q & ~cur_bit) : trim_q;
    if (idx_q != '0) trim_d = trim_d | (cur_bit >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      trim_q     <= '0;
      bk_trim_q  <= '0;
      bk_valid_q <= 1'b0;
      cal_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (load_i) begin
          trim_q  <= load_code_i;
          valid_q <= 1'b1;
        end else if (start_i) begin
          state_q    <= S_INIT;
          bk_trim_q  <= trim_q;
          bk_valid_q <= valid_q;
          // Trial codes are not usable results until the run finishes.
          valid_q    <= 1'b0;
          trim_q     <= '0;
          cal_en_q   <= 1'b1;
          busy_q     <= 1'b1;
          cnt_q      <= SETTLE;
          idx_q      <= IDX_TOP;
        end
      end else if (abort_i) begin
        // Abort wins over everything, including the final DECIDE.
        state_q  <= S_IDLE;
        trim_q   <= bk_trim_q;
        valid_q  <= bk_valid_q;
        cal_en_q <= 1'b0;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
      end else begin
        case (state_q)
          S_INIT: begin
            // Counter is loaded with SETTLE and leaves at 1, so it never
            // reaches zero or wraps.
            if (cnt_q == CNT_ONE) begin
              state_q <= S_WAIT;
              trim_q  <= TRIM_MSB;
              cnt_q   <= SETTLE;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          S_WAIT: begin
            if (cnt_q == CNT_ONE) begin
              state_q <= S_DECIDE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          S_DECIDE: begin
            trim_q <= trim_d;
            if (idx_q != '0) begin
              idx_q   <= idx_q - IDX_ONE;
              cnt_q   <= SETTLE;
              state_q <= S_WAIT;
            end else begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              valid_q  <= 1'b1;
              cal_en_q <= 1'b0;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q  <= S_IDLE;
            cal_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign trim_o   = trim_q;
  assign cal_en_o = cal_en_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_opamp_trim_cal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_opamp_trim_cal_ctrl
//   Self-checking bench for opamp_trim_cal_ctrl (TRIM_W=6, SETTLE_CYCLES=4).
//   The opamp is modelled as "cmp = trim > target". The expected calibrated
//   code is therefore the largest code not above target, clamped to the code
//   range. Loads and aborts are tracked with a small model of the last good
//   trim/valid pair.
// ---------------------------------------------------------------------------
module tb_opamp_trim_cal_ctrl;

  localparam int TW = 6;
  localparam int SC = 4;
  localparam int EXP_LAT = 1 + SC + TW * (SC + 1);
  localparam int CODE_MAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, load;
  logic [TW-1:0] load_code;
  logic          cmp_in;
  logic [TW-1:0] trim;
  logic          cal_en, busy, done, valid;

  int   target;
  logic noise_en, noise_q;

  int   nchk = 0;
  int   nerr = 0;
  int   m_trim;
  int   m_valid;

  always #5 clk = ~clk;

  always @(posedge clk) noise_q <= 1'($urandom);
  assign cmp_in = noise_en ? noise_q : (int'(trim) > target);

  opamp_trim_cal_ctrl #(.TRIM_W(TW), .SETTLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .abort_i     (abort),
    .load_i      (load),
    .load_code_i (load_code),
    .cmp_in_i    (cmp_in),
    .trim_o      (trim),
    .cal_en_o    (cal_en),
    .busy_o      (busy),
    .done_o      (done),
    .valid_o     (valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_code(input int t);
    if (t < 0) return 0;
    if (t > CODE_MAX) return CODE_MAX;
    return t;
  endfunction

  // Manual load, optionally with a competing start in the same cycle.
  // Caller is positioned at a negedge.
  task automatic do_load(input int code, input bit with_start);
    load = 1'b1; load_code = TW'(code); start = with_start;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    m_trim = code; m_valid = 1;
    chk("load_trim", trim, code);
    chk("load_valid", valid, 1);
    chk("load_busy", busy, 0);
    @(negedge clk);
    chk("load_busy_hold", busy, 0);
    chk("load_done", done, 0);
  endtask

  // One calibration run from the current negedge. n counts clock edges with
  // the edge that samples start as edge 1.
  task automatic run_cal(input int tgt, input bit noise, input bit spam, input int abort_at,
                         output int lat, output int ndone, output int t_done,
                         output int v_done, output int c_done);
    int n;
    lat = 0; ndone = 0; t_done = -1; v_done = -1; c_done = -1;
    target = tgt; noise_en = noise;
    start = 1'b1; abort = 1'b0; load = 1'b0;
    @(posedge clk);
    n = 1;
    forever begin
      @(negedge clk);
      if (n == 1) begin
        chk("busy_rise", busy, 1);
        chk("cal_en_rise", cal_en, 1);
      end
      if (n > SC) noise_en = 1'b0;
      if (spam && lat == 0 && n < EXP_LAT - 2 && (abort_at == 0 || n < abort_at)) begin
        start     = 1'($urandom);
        load      = 1'($urandom);
        load_code = TW'($urandom);
      end else begin
        start = 1'b0;
        load  = 1'b0;
      end
      abort = (n == abort_at);
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) begin
          lat = n; t_done = int'(trim); v_done = int'(valid); c_done = int'(cal_en);
        end
      end
      if (abort_at != 0 && n >= abort_at + 12) break;
      if (abort_at == 0 && lat != 0 && n >= lat + 3) break;
      if (n >= 300) break;
      @(posedge clk);
      n++;
    end
    start = 1'b0; load = 1'b0; abort = 1'b0; noise_en = 1'b0;
  endtask

  task automatic do_run(input int tgt, input bit noise, input bit spam, input int abort_at);
    int lat, ndone, t_done, v_done, c_done;
    run_cal(tgt, noise, spam, abort_at, lat, ndone, t_done, v_done, c_done);
    if (abort_at == 0) begin
      chk("latency", lat, EXP_LAT);
      chk("done_count", ndone, 1);
      chk("result", t_done, clamp_code(tgt));
      chk("valid_at_done", v_done, 1);
      chk("cal_en_at_done", c_done, 0);
      chk("busy_after", busy, 0);
      m_trim = clamp_code(tgt); m_valid = 1;
    end else begin
      chk("abort_no_done", ndone, 0);
      chk("abort_busy", busy, 0);
      chk("abort_trim", trim, m_trim);
      chk("abort_valid", valid, m_valid);
      chk("abort_cal_en", cal_en, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; load = 1'b0; load_code = '0;
    target = 0; noise_en = 1'b0;
    m_trim = 0; m_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_trim", trim, 0);
    chk("rst_cal_en", cal_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);

    // Start accepted on the first edge after reset release.
    rst = 1'b0;
    do_run(37, 1'b0, 1'b0, 0);
    @(negedge clk);
    do_run(-1, 1'b0, 1'b0, 0);
    @(negedge clk);
    do_run(1000, 1'b0, 1'b0, 0);

    // Load beats a simultaneous start.
    @(negedge clk);
    do_load(12, 1'b1);

    // Abort at cycle 20 restores the loaded code.
    do_run(50, 1'b0, 1'b0, 20);

    // Abort coinciding with the final DECIDE wins.
    @(negedge clk);
    do_run(20, 1'b0, 1'b0, EXP_LAT - 1);

    // Comparator noise during INIT and start/load pulses while busy.
    @(negedge clk);
    do_run(37, 1'b1, 1'b1, 0);

    // Reset in the middle of a run.
    @(negedge clk);
    target = 37; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_trim", trim, 0);
    chk("midrst_cal_en", cal_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    m_trim = 0; m_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    do_run(37, 1'b0, 1'b0, 0);

    // Randomized mix of loads, targets, noise, busy spam and aborts.
    for (int i = 0; i < 12; i++) begin
      int tgt, ab;
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) do_load(int'($urandom_range(0, CODE_MAX)), 1'($urandom));
      case ($urandom_range(0, 7))
        0:       tgt = -int'($urandom_range(1, 9));
        1:       tgt = CODE_MAX + int'($urandom_range(1, 40));
        default: tgt = int'($urandom_range(0, CODE_MAX));
      endcase
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, EXP_LAT - 1)) : 0;
      do_run(tgt, 1'($urandom), 1'($urandom), ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
